// File: rtl/ad9434_tx_emu.sv
// AD9434 DDR LVDS output emulator: sample FIFO or internal generator -> rise/fall half-words.
// Optional PRBS-15 generator for mode 3 is compiled in when AD9434_TX_PRBS_EN is defined.
module ad9434_tx_emu #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned TRAIN_CYCLES = 64,
    parameter logic [11:0] TRAIN_WORD   = 12'hFC0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [11:0] cfg_fixed,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [11:0] s_data,
    input  logic        s_or,
    output logic [5:0]  tx_d_rise,
    output logic [5:0]  tx_d_fall,
    output logic        tx_or,
    output logic        tx_dco_en,
    output logic        underflow,
    output logic [1:0]  state_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] TrainLast = CW'(TRAIN_CYCLES - 1);

    localparam logic [1:0] ModeStream = 2'd0;
    localparam logic [1:0] ModeFixed  = 2'd2;
`ifdef AD9434_TX_PRBS_EN
    localparam logic [1:0] ModePrbs   = 2'd3;
`endif

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTrain = 2'd1,
        StRun   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [11:0]   sample_q, sample_d;
    logic          or_q, or_d;
    logic          uf_q, uf_d;
    logic [11:0]   ramp_q, ramp_d;
    logic [11:0]   ramp_cur;
    logic          run_entry, run_go;

    logic [AW:0]   wptr_q, rptr_q;
    logic [12:0]   mem_q [FIFO_DEPTH];
    logic [12:0]   head;
    logic          push, pop, flush, full, empty;

`ifdef AD9434_TX_PRBS_EN
    logic [14:0]   lfsr_q, lfsr_d, lfsr_next;

    // Twelve serial steps of x^15+x^14+1; first generated bit lands in the sample MSB.
    always_comb begin
        lfsr_next = run_entry ? 15'h7FFF : lfsr_q;
        for (int i = 0; i < 12; i++) begin
            lfsr_next = {lfsr_next[13:0], lfsr_next[14] ^ lfsr_next[13]};
        end
    end
`endif

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head  = mem_q[rptr_q[AW-1:0]];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts while streaming.
    assign s_ready = !rst && enable && (state_q != StIdle) && (!full || pop);
    assign push    = s_valid && s_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        sample_d = sample_q;
        or_d     = or_q;
        uf_d     = uf_q;
        ramp_d   = ramp_q;
        pop      = 1'b0;
        flush    = 1'b0;
`ifdef AD9434_TX_PRBS_EN
        lfsr_d   = lfsr_q;
`endif
        run_entry = (state_q == StTrain) && (cnt_q == TrainLast);
        run_go    = run_entry || (state_q == StRun);
        ramp_cur  = run_entry ? 12'h000 : ramp_q;

        unique case (state_q)
            StIdle: begin
                flush = 1'b1;
                if (enable) begin
                    state_d  = StTrain;
                    mode_d   = mode;
                    cnt_d    = '0;
                    sample_d = TRAIN_WORD;
                    or_d     = 1'b0;
                end
            end
            StTrain: begin
                if (run_entry) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
            end
            default: state_d = StIdle;
        endcase

        // Output registers always hold the sample for the state being entered.
        if (run_go) begin
            unique case (mode_q)
                ModeStream: begin
                    if (!empty) begin
                        pop              = 1'b1;
                        {or_d, sample_d} = head;
                    end else begin
                        uf_d = 1'b1;
                    end
                end
                ModeFixed: begin
                    sample_d = cfg_fixed;
                    or_d     = 1'b0;
                end
`ifdef AD9434_TX_PRBS_EN
                ModePrbs: begin
                    sample_d = lfsr_next[11:0];
                    or_d     = 1'b0;
                    lfsr_d   = lfsr_next;
                end
`endif
                default: begin
                    sample_d = ramp_cur;
                    or_d     = &ramp_cur;
                    ramp_d   = ramp_cur + 12'd1;
                end
            endcase
        end

        if (!enable) begin
            state_d  = StIdle;
            cnt_d    = '0;
            sample_d = '0;
            or_d     = 1'b0;
            uf_d     = 1'b0;
            ramp_d   = '0;
            pop      = 1'b0;
            flush    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mode_q   <= 2'd0;
            sample_q <= '0;
            or_q     <= 1'b0;
            uf_q     <= 1'b0;
            ramp_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
`ifdef AD9434_TX_PRBS_EN
            lfsr_q   <= 15'h7FFF;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            sample_q <= sample_d;
            or_q     <= or_d;
            uf_q     <= uf_d;
            ramp_q   <= ramp_d;
`ifdef AD9434_TX_PRBS_EN
            lfsr_q   <= lfsr_d;
`endif
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {s_or, s_data};
        end
    end

    assign tx_d_rise = sample_q[11:6];
    assign tx_d_fall = sample_q[5:0];
    assign tx_or     = or_q;
    assign tx_dco_en = (state_q != StIdle);
    assign underflow = uf_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_ad9434_tx_emu.sv
// Directed bench for ad9434_tx_emu: training, ramp wrap, stream/FIFO, fixed table, mode 3, reset.
// Mode 3 expectations follow AD9434_TX_PRBS_EN the same way the design does.
module tb_ad9434_tx_emu;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] cfg_fixed;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_data;
    logic        s_or;
    logic [5:0]  tx_d_rise;
    logic [5:0]  tx_d_fall;
    logic        tx_or;
    logic        tx_dco_en;
    logic        underflow;
    logic [1:0]  state_o;

    int total = 0;
    int bad   = 0;

    ad9434_tx_emu dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .cfg_fixed (cfg_fixed),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_or      (s_or),
        .tx_d_rise (tx_d_rise),
        .tx_d_fall (tx_d_fall),
        .tx_or     (tx_or),
        .tx_dco_en (tx_dco_en),
        .underflow (underflow),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [11:0] cfg;
        logic [11:0] smp;
        logic        dco;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Packs {sample, or, dco_en, underflow, state} for one comparison.
    task automatic expect_tx(input string nm, input logic [11:0] smp, input logic orb,
                             input logic dco, input logic uf, input logic [1:0] st);
        chk(nm, {15'd0, tx_d_rise, tx_d_fall, tx_or, tx_dco_en, underflow, state_o},
            {15'd0, smp, orb, dco, uf, st});
    endtask

    task automatic enter_run();
        tick();
        repeat (64) tick();
    endtask

    function automatic logic [11:0] prbs_word(input int n);
        logic [14:0] s;
        logic [11:0] w;
        logic        b;
        s = 15'h7FFF;
        w = '0;
        for (int i = 0; i < 12 * (n + 1); i++) begin
            b = s[14] ^ s[13];
            s = {s[13:0], b};
            w = {w[10:0], b};
        end
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pidx;
        logic [11:0] exp_s;

        vecs[0] = '{1'b1, 12'h000, 12'h000, 1'b1, 2'd2};
        vecs[1] = '{1'b1, 12'hFFF, 12'hFFF, 1'b1, 2'd2};
        vecs[2] = '{1'b1, 12'h5A5, 12'h5A5, 1'b1, 2'd2};
        vecs[3] = '{1'b1, 12'h5A5, 12'h5A5, 1'b1, 2'd2};
        vecs[4] = '{1'b0, 12'h777, 12'h000, 1'b0, 2'd0};
        vecs[5] = '{1'b1, 12'h777, 12'hFC0, 1'b1, 2'd1};

        rst = 1'b1; enable = 1'b0; mode = 2'd0; cfg_fixed = '0;
        s_valid = 1'b0; s_data = '0; s_or = 1'b0;
        tick(); tick();
        rst = 1'b0;
        expect_tx("reset_out", 12'h000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("reset_ready", s_ready, 0);

        // Training then ramp through the 12-bit wrap; mode input changes are ignored.
        enable = 1'b1; mode = 2'd1;
        tick();
        for (int i = 0; i < 64; i++) begin
            expect_tx("train", 12'hFC0, 1'b0, 1'b1, 1'b0, 2'd1);
            if (i == 0) chk("train_ready", s_ready, 1);
            tick();
        end
        for (int k = 0; k < 4098; k++) begin
            exp_s = 12'(k);
            expect_tx("ramp", exp_s, (exp_s == 12'hFFF), 1'b1, 1'b0, 2'd2);
            if (k == 10) mode = 2'd2;
            tick();
        end
        enable = 1'b0;
        tick();
        expect_tx("ramp_off", 12'h000, 1'b0, 1'b0, 1'b0, 2'd0);

        // Stream: two samples pushed during training, then underflow repeat.
        enable = 1'b1; mode = 2'd0;
        tick();
        s_valid = 1'b1; s_data = 12'h123; s_or = 1'b0;
        tick();
        s_data = 12'hABC; s_or = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (62) tick();
        expect_tx("stream_0", 12'h123, 1'b0, 1'b1, 1'b0, 2'd2);
        tick();
        expect_tx("stream_1", 12'hABC, 1'b1, 1'b1, 1'b0, 2'd2);
        tick();
        expect_tx("stream_uf", 12'hABC, 1'b1, 1'b1, 1'b1, 2'd2);
        s_valid = 1'b1; s_data = 12'h555; s_or = 1'b0;
        tick();
        s_valid = 1'b0;
        expect_tx("stream_uf_hold", 12'hABC, 1'b1, 1'b1, 1'b1, 2'd2);
        tick();
        expect_tx("stream_late", 12'h555, 1'b0, 1'b1, 1'b1, 2'd2);
        enable = 1'b0;
        tick();
        expect_tx("stream_off", 12'h000, 1'b0, 1'b0, 1'b0, 2'd0);

        // Fill the FIFO during training, then push and pop together while full.
        enable = 1'b1; mode = 2'd0;
        tick();
        pidx = 0;
        s_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            s_data = 12'h100 + 12'(pidx); s_or = pidx[0];
            if (t == 20) begin
                chk("full_count", pidx, 16);
                chk("full_ready", s_ready, 0);
            end
            if (t == 63) chk("full_pop_ready", s_ready, 1);
            if (s_ready) pidx++;
            tick();
        end
        for (int r = 0; r < 10; r++) begin
            expect_tx("full_stream", 12'h100 + 12'(r), r[0], 1'b1, 1'b0, 2'd2);
            chk("full_stream_ready", s_ready, 1);
            s_data = 12'h100 + 12'(pidx); s_or = pidx[0];
            if (s_ready) pidx++;
            tick();
        end
        s_valid = 1'b0;
        enable = 1'b0;
        tick();
        expect_tx("flush_off", 12'h000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("flush_ready", s_ready, 0);
        enable = 1'b1;
        enter_run();
        tick();
        chk("flush_empty_uf", {underflow, state_o}, {1'b1, 2'd2});
        enable = 1'b0;
        tick();

        // Fixed mode follows cfg_fixed one cycle later.
        enable = 1'b1; mode = 2'd2; cfg_fixed = 12'h3C3;
        enter_run();
        expect_tx("fixed_first", 12'h3C3, 1'b0, 1'b1, 1'b0, 2'd2);
        for (int v = 0; v < 6; v++) begin
            enable = vecs[v].en; cfg_fixed = vecs[v].cfg;
            tick();
            expect_tx($sformatf("fixed_vec%0d", v), vecs[v].smp, 1'b0, vecs[v].dco, 1'b0,
                      vecs[v].st);
        end
        enable = 1'b0;
        tick();

        // Mode 3: PRBS-15 when compiled in, otherwise a copy of the ramp.
        enable = 1'b1; mode = 2'd3;
        enter_run();
        for (int k = 0; k < 8; k++) begin
`ifdef AD9434_TX_PRBS_EN
            expect_tx("prbs", prbs_word(k), 1'b0, 1'b1, 1'b0, 2'd2);
`else
            expect_tx("mode3_ramp", 12'(k), 1'b0, 1'b1, 1'b0, 2'd2);
`endif
            tick();
        end

        // Reset mid-run behaves like power-up, then restarts training.
        rst = 1'b1;
        tick();
        expect_tx("rst_mid", 12'h000, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("rst_mid_ready", s_ready, 0);
        rst = 1'b0;
        tick();
        expect_tx("rst_retrain", 12'hFC0, 1'b0, 1'b1, 1'b0, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
